// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage IOPipe core. It generates stall, bubble and flush
// requests and EX operand forwarding selects from a shadow pipeline of destination tags.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dest,
    input  logic             id_rs_read,
    input  logic             id_rt_read,
    input  logic             id_reg_wen,
    input  logic             id_lw,
    input  logic             id_isJump,
    input  logic             id_isJR,
    input  logic             mem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic             freeze,
    output logic [1:0]       fwd_rs_sel,
    output logic [1:0]       fwd_rt_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_FRZ  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // WB only needs its tag for forwarding, so it carries no load flag.
    logic       ex_v_q, ex_wen_q, ex_lw_q, mem_v_q, mem_wen_q, mem_lw_q, wb_v_q, wb_wen_q;
    logic       ex_v_d, ex_wen_d, ex_lw_d, mem_v_d, mem_wen_d, mem_lw_d, wb_v_d, wb_wen_d;
    logic [4:0] ex_dest_q, ex_rs_q, ex_rt_q, mem_dest_q, wb_dest_q;
    logic [4:0] ex_dest_d, ex_rs_d, ex_rt_d, mem_dest_d, wb_dest_d;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_en_s;

    logic ex_live_s, mem_live_s, wb_live_s;
    logic load_use_s, jr_haz_s, hazard_s, stall_s;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       m_live,
        input logic       m_lw,
        input logic [4:0] m_dest,
        input logic       w_live,
        input logic [4:0] w_dest
    );
        logic [1:0] sel;
        if (m_live && !m_lw && (m_dest == src)) begin
            sel = 2'b01;
        end else if (w_live && (w_dest == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection and front-end control
    always_comb begin
        ex_live_s  = ex_v_q  && ex_wen_q  && (ex_dest_q  != 5'd0);
        mem_live_s = mem_v_q && mem_wen_q && (mem_dest_q != 5'd0);
        wb_live_s  = wb_v_q  && wb_wen_q  && (wb_dest_q  != 5'd0);
        load_use_s = id_valid && ex_live_s && ex_lw_q &&
                     ((id_rs_read && (id_rs == ex_dest_q)) ||
                      (id_rt_read && (id_rt == ex_dest_q)));
        // JR resolves in ID: ALU results come from MEM, loads must reach WB first.
        jr_haz_s   = id_valid && id_isJR &&
                     ((ex_live_s && (id_rs == ex_dest_q)) ||
                      (mem_live_s && mem_lw_q && (id_rs == mem_dest_q)));
        hazard_s   = load_use_s || jr_haz_s;
        stall_s    = hazard_s && !mem_busy;
        freeze     = mem_busy;
        stall_if   = stall_s;
        stall_id   = stall_s;
        bubble_ex  = stall_s;
        flush_if   = (id_isJump || id_isJR) && id_valid && !stall_s && !mem_busy;
        fwd_rs_sel = fwd_sel(ex_rs_q, mem_live_s, mem_lw_q, mem_dest_q, wb_live_s, wb_dest_q);
        fwd_rt_sel = fwd_sel(ex_rt_q, mem_live_s, mem_lw_q, mem_dest_q, wb_live_s, wb_dest_q);
    end

    // Shadow pipeline advance
    always_comb begin
        if (!mem_busy) begin
            wb_v_d     = mem_v_q;
            wb_wen_d   = mem_wen_q;
            wb_dest_d  = mem_dest_q;
            mem_v_d    = ex_v_q;
            mem_wen_d  = ex_wen_q;
            mem_lw_d   = ex_lw_q;
            mem_dest_d = ex_dest_q;
            ex_v_d     = id_valid && !stall_s;
            ex_wen_d   = id_reg_wen;
            ex_lw_d    = id_lw;
            ex_dest_d  = id_dest;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
        end else begin
            wb_v_d     = wb_v_q;
            wb_wen_d   = wb_wen_q;
            wb_dest_d  = wb_dest_q;
            mem_v_d    = mem_v_q;
            mem_wen_d  = mem_wen_q;
            mem_lw_d   = mem_lw_q;
            mem_dest_d = mem_dest_q;
            ex_v_d     = ex_v_q;
            ex_wen_d   = ex_wen_q;
            ex_lw_d    = ex_lw_q;
            ex_dest_d  = ex_dest_q;
            ex_rs_d    = ex_rs_q;
            ex_rt_d    = ex_rt_q;
        end
    end

    // Shadow pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q     <= 1'b0;
            ex_wen_q   <= 1'b0;
            ex_lw_q    <= 1'b0;
            ex_dest_q  <= 5'd0;
            ex_rs_q    <= 5'd0;
            ex_rt_q    <= 5'd0;
            mem_v_q    <= 1'b0;
            mem_wen_q  <= 1'b0;
            mem_lw_q   <= 1'b0;
            mem_dest_q <= 5'd0;
            wb_v_q     <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_dest_q  <= 5'd0;
        end else begin
            ex_v_q     <= ex_v_d;
            ex_wen_q   <= ex_wen_d;
            ex_lw_q    <= ex_lw_d;
            ex_dest_q  <= ex_dest_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            mem_v_q    <= mem_v_d;
            mem_wen_q  <= mem_wen_d;
            mem_lw_q   <= mem_lw_d;
            mem_dest_q <= mem_dest_d;
            wb_v_q     <= wb_v_d;
            wb_wen_q   <= wb_wen_d;
            wb_dest_q  <= wb_dest_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d = ST_FRZ;
                end else if (hazard_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (mem_busy) begin
                    state_d = ST_FRZ;
                end else if (!hazard_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_FRZ: begin
                if (mem_busy) begin
                    state_d = ST_FRZ;
                end else if (hazard_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM output: the cycle being entered is a counted stall/freeze cycle
    always_comb begin
        case (state_d)
            ST_RUN:  cnt_en_s = 1'b0;
            ST_HOLD: cnt_en_s = 1'b1;
            ST_FRZ:  cnt_en_s = 1'b1;
            default: cnt_en_s = 1'b0;
        endcase
    end

    // Saturating stall counter next value
    always_comb begin
        if (cnt_en_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl; expected outputs come from a tag-pipeline
// model and are checked by a monitor that pops a scoreboard queue each cycle.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid, rs_read, rt_read, wen, lw, jump, jr;
        logic [4:0] rs, rt, dest;
    } ins_t;

    typedef struct packed {
        logic       v, wen, lw;
        logic [4:0] dest, rs, rt;
    } tag_t;

    typedef struct packed {
        logic        s_if, s_id, bub, fl, frz;
        logic [1:0]  frs, frt;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_rs_read, id_rt_read, id_reg_wen, id_lw, id_isJump, id_isJR, mem_busy;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        stall_if, stall_id, bubble_ex, flush_if, freeze;
    logic [1:0]  fwd_rs_sel, fwd_rt_sel;
    logic [15:0] stall_cnt;
    logic        s_stall_if, s_stall_id, s_bubble_ex, s_flush_if, s_freeze;
    logic [1:0]  s_fwd_rs_sel, s_fwd_rt_sel;
    logic [3:0]  s_stall_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    exp_t        sb_q[$];

    tag_t        pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
    int unsigned m_c16 = 0;
    int unsigned m_c4 = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read), .id_reg_wen(id_reg_wen), .id_lw(id_lw),
        .id_isJump(id_isJump), .id_isJR(id_isJR), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
        .freeze(freeze), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read), .id_reg_wen(id_reg_wen), .id_lw(id_lw),
        .id_isJump(id_isJump), .id_isJR(id_isJR), .mem_busy(mem_busy),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_ex(s_bubble_ex), .flush_if(s_flush_if),
        .freeze(s_freeze), .fwd_rs_sel(s_fwd_rs_sel), .fwd_rt_sel(s_fwd_rt_sel), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic bit live(input tag_t t);
        return t.v && t.wen && (t.dest != 5'd0);
    endfunction

    function automatic bit m_hazard(input ins_t i);
        bit lu, jr;
        if (!i.valid) return 1'b0;
        lu = live(pipe[0]) && pipe[0].lw &&
             ((i.rs_read && i.rs == pipe[0].dest) || (i.rt_read && i.rt == pipe[0].dest));
        jr = i.jr && ((live(pipe[0]) && i.rs == pipe[0].dest) ||
                      (live(pipe[1]) && pipe[1].lw && i.rs == pipe[1].dest));
        return lu || jr;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (live(pipe[1]) && !pipe[1].lw && pipe[1].dest == r) return 2'b01;
        if (live(pipe[2]) && pipe[2].dest == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic ins_t mk(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dest, input bit rsr, input bit rtr,
                                input bit wen, input bit lw, input bit j, input bit jr);
        ins_t i;
        i.valid = v; i.rs = rs; i.rt = rt; i.dest = dest; i.rs_read = rsr; i.rt_read = rtr;
        i.wen = wen; i.lw = lw; i.jump = j; i.jr = jr;
        return i;
    endfunction

    // One clock cycle: drive, predict, push, then advance the model past the edge.
    task automatic cycle(input ins_t i, input bit busy, input bit r, input bit push, output bit stalled);
        exp_t e;
        bit   st;
        id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_dest = i.dest;
        id_rs_read = i.rs_read; id_rt_read = i.rt_read; id_reg_wen = i.wen; id_lw = i.lw;
        id_isJump = i.jump; id_isJR = i.jr; mem_busy = busy; rst = r;
        #1;
        st    = m_hazard(i) && !busy;
        e.s_if = st; e.s_id = st; e.bub = st; e.frz = busy;
        e.fl  = (i.jump || i.jr) && i.valid && !st && !busy;
        e.frs = m_fwd(pipe[0].rs);
        e.frt = m_fwd(pipe[0].rt);
        e.c16 = m_c16[15:0];
        e.c4  = m_c4[3:0];
        if (push) sb_q.push_back(e);
        stalled = st;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
            m_c16 = 0;
            m_c4  = 0;
        end else begin
            if (st || busy) begin
                m_c16 = (m_c16 < 65535) ? m_c16 + 1 : 65535;
                m_c4  = (m_c4 < 15) ? m_c4 + 1 : 15;
            end
            if (!busy) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0].v = i.valid && !st; pipe[0].wen = i.wen; pipe[0].lw = i.lw;
                pipe[0].dest = i.dest; pipe[0].rs = i.rs; pipe[0].rt = i.rt;
            end
        end
        #1;
    endtask

    // Present an instruction and keep it in ID until it is no longer stalled.
    task automatic issue(input ins_t i);
        bit st;
        int n = 0;
        do begin
            cycle(i, 1'b0, 1'b0, 1'b1, st);
            n++;
        end while (st && n < 8);
        if (st) chk("issue_stall_bound", 1, 0);
    endtask

    task automatic do_reset();
        bit st;
        cycle(mk(0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1, 1'b0, st);
        cycle(mk(0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1, 1'b0, st);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("stall_if",   stall_if,    e.s_if);
            chk("stall_id",   stall_id,    e.s_id);
            chk("bubble_ex",  bubble_ex,   e.bub);
            chk("flush_if",   flush_if,    e.fl);
            chk("freeze",     freeze,      e.frz);
            chk("fwd_rs_sel", fwd_rs_sel,  e.frs);
            chk("fwd_rt_sel", fwd_rt_sel,  e.frt);
            chk("stall_cnt",  stall_cnt,   e.c16);
            chk("stall_cnt4", s_stall_cnt, e.c4);
        end
    end

    initial begin
        ins_t nop, lw5, add6, add3, sub4, and8, addi0, add_r0, lw31, add31, jr31, cur;
        bit   st, busy, r, last_hold;
        nop    = mk(0, 0, 0, 0, 0,0,0,0,0,0);
        lw5    = mk(1, 1, 5, 5, 1,0,1,1,0,0);
        add6   = mk(1, 5, 1, 6, 1,1,1,0,0,0);
        add3   = mk(1, 1, 2, 3, 1,1,1,0,0,0);
        sub4   = mk(1, 3, 3, 4, 1,1,1,0,0,0);
        and8   = mk(1, 3, 1, 8, 1,1,1,0,0,0);
        addi0  = mk(1, 1, 0, 0, 1,0,1,0,0,0);
        add_r0 = mk(1, 0, 0, 7, 1,1,1,0,0,0);
        lw31   = mk(1, 1, 31, 31, 1,0,1,1,0,0);
        add31  = mk(1, 1, 2, 31, 1,1,1,0,0,0);
        jr31   = mk(1, 31, 0, 0, 1,0,0,0,0,1);
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        @(posedge clk); #1;
        do_reset();
        issue(nop);

        issue(lw5); issue(add6); issue(nop); issue(nop);
        chk("cnt_load_use", stall_cnt, 1);

        issue(add3); issue(sub4); issue(and8); issue(nop); issue(nop);
        issue(addi0); issue(add_r0); issue(nop); issue(nop);
        chk("cnt_no_stall", stall_cnt, 1);

        do_reset();
        issue(lw31); issue(jr31); issue(nop);
        chk("cnt_jr_after_lw", stall_cnt, 2);
        issue(add31); issue(jr31); issue(nop);
        chk("cnt_jr_after_alu", stall_cnt, 3);

        do_reset();
        issue(lw5);
        cycle(add6, 1'b0, 1'b0, 1'b1, st);
        for (int k = 0; k < 3; k++) cycle(add6, 1'b1, 1'b0, 1'b1, st);
        issue(add6); issue(nop);
        chk("cnt_freeze_stall", stall_cnt, 4);

        issue(lw5);
        cycle(add6, 1'b0, 1'b0, 1'b1, st);
        cycle(add6, 1'b1, 1'b0, 1'b1, st);
        cycle(add6, 1'b1, 1'b1, 1'b1, st);
        cycle(nop, 1'b0, 1'b0, 1'b1, st);
        chk("cnt_after_rst", stall_cnt, 0);
        chk("stall_after_rst", stall_id, 0);

        cur = nop;
        last_hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!last_hold) begin
                cur = mk($urandom_range(0, 5) != 0,
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                         $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, 1'b0);
                if ($urandom_range(0, 7) == 0) begin
                    cur.jr = 1'b1; cur.rs_read = 1'b1;
                    if ($urandom_range(0, 1) == 1) cur.rs = 5'd31;
                end
            end
            busy = $urandom_range(0, 7) == 0;
            r    = $urandom_range(0, 199) == 0;
            cycle(cur, busy, r, 1'b1, st);
            last_hold = (st || busy) && !r;
        end

        do_reset();
        for (int n = 0; n < 65540; n++) cycle(nop, 1'b1, 1'b0, 1'b1, st);
        chk("cnt16_saturate", stall_cnt, 65535);
        chk("cnt4_saturate", s_stall_cnt, 15);
        cycle(nop, 1'b0, 1'b0, 1'b1, st);
        chk("cnt16_hold_max", stall_cnt, 65535);

        @(negedge clk); #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
